// File: rtl/note_pkg.sv
// Shared types and constants for the note RAM writer and the note sequencer.
package note_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4
    } writer_state_t;

    localparam logic [15:0] END_WORD = 16'h0000;

    // Note word layout as decoded by note_sequencer: pitch in the high byte, duration in the low byte.
    localparam int NOTE_PITCH_MSB = 15;
    localparam int NOTE_PITCH_LSB = 8;
    localparam int NOTE_DUR_MSB   = 7;
    localparam int NOTE_DUR_LSB   = 0;

endpackage

// File: rtl/note_byte_packer.sv
// Assembles big-endian byte pairs into 16-bit note words; o_word_valid pulses for one cycle per word.
module note_byte_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hi_load,
    input  logic        i_lo_load,
    input  logic [7:0]  i_byte,
    output logic [7:0]  o_hi_byte,
    output logic        o_word_valid,
    output logic [15:0] o_word
);

    logic [7:0]  r_hi;
    logic [15:0] r_word;
    logic        r_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hi    <= 8'h00;
            r_word  <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_lo_load;
            if (i_hi_load) begin
                r_hi <= i_byte;
            end
            if (i_lo_load) begin
                r_word <= {r_hi, i_byte};
            end
        end
    end

    assign o_hi_byte    = r_hi;
    assign o_word_valid = r_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/note_pattern_writer.sv
// Loads a byte stream into the note RAM as 16-bit words until END_WORD or the last address.
// Optional trailing XOR checksum byte is enabled by defining NOTE_WRITER_CHECKSUM_EN.
module note_pattern_writer
    import note_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 17,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [WIDTH-1:0]  o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_length,
    output logic              o_error
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    writer_state_t r_state;
    writer_state_t w_state_next;

    logic [ADDR_W:0]   r_next_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_length;

    logic        w_ready;
    logic        w_accept;
    logic        w_hi_load;
    logic        w_lo_load;
    logic        w_last;
    logic        w_enter_done;
    logic [7:0]  w_hi_byte;
    logic        w_word_valid;
    logic [15:0] w_word;

    // A byte offered alongside i_start is never consumed.
    assign w_accept  = i_byte_valid & w_ready & ~i_start;
    assign w_hi_load = w_accept & (r_state == S_HI);
    assign w_lo_load = w_accept & (r_state == S_LO);
    assign w_last    = w_lo_load &
                       (({w_hi_byte, i_byte} == END_WORD) || (r_next_addr == LAST_ADDR));
    assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);

    note_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_hi_load    (w_hi_load),
        .i_lo_load    (w_lo_load),
        .i_byte       (i_byte),
        .o_hi_byte    (w_hi_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef NOTE_WRITER_CHECKSUM_EN
    logic       w_cs_load;
    logic [7:0] r_csum;
    logic       r_error;

    assign w_cs_load = w_accept & (r_state == S_CSUM);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_csum  <= 8'h00;
            r_error <= 1'b0;
        end else if (i_start) begin
            r_csum  <= 8'h00;
            r_error <= 1'b0;
        end else begin
            if (w_hi_load || w_lo_load) begin
                r_csum <= r_csum ^ i_byte;
            end
            if (w_cs_load) begin
                r_error <= (i_byte != r_csum);
            end
        end
    end

    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        if (i_start) begin
            w_state_next = S_HI;
        end else begin
            case (r_state)
                S_IDLE: w_state_next = S_IDLE;
                S_HI:   if (w_hi_load) w_state_next = S_LO;
                S_LO: begin
                    if (w_lo_load) begin
`ifdef NOTE_WRITER_CHECKSUM_EN
                        w_state_next = w_last ? S_CSUM : S_HI;
`else
                        w_state_next = w_last ? S_DONE : S_HI;
`endif
                    end
                end
`ifdef NOTE_WRITER_CHECKSUM_EN
                S_CSUM: if (w_cs_load) w_state_next = S_DONE;
`endif
                S_DONE: w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Write address trails the counter so it is stable during the write cycle and holds afterwards.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_next_addr <= '0;
            r_wr_addr   <= '0;
            r_length    <= '0;
        end else if (i_start) begin
            r_next_addr <= '0;
            r_wr_addr   <= '0;
        end else begin
            if (w_lo_load) begin
                r_wr_addr   <= r_next_addr[ADDR_W-1:0];
                r_next_addr <= r_next_addr + 1'b1;
            end
            if (w_enter_done) begin
                r_length <= w_lo_load ? (r_next_addr + 1'b1) : r_next_addr;
            end
        end
    end

    always_comb begin
        w_ready = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            S_HI, S_LO, S_CSUM: begin
                w_ready = 1'b1;
                o_busy  = 1'b1;
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_byte_ready = w_ready;
    assign o_wr_en      = w_word_valid;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = WIDTH'(w_word);
    assign o_length     = r_length;

endmodule

// File: tb/tb_note_pattern_writer.sv
// Directed bench for note_pattern_writer; covers the checksum option when NOTE_WRITER_CHECKSUM_EN is defined.
module tb_note_pattern_writer;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 17;
    localparam int ADDR_W = 5;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_start;
    logic              i_byte_valid;
    logic [7:0]        i_byte;
    logic              o_byte_ready;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [WIDTH-1:0]  o_wr_data;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W:0]   o_length;
    logic              o_error;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [ADDR_W+WIDTH-1:0] wr_q[$];

    note_pattern_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_length     (o_length),
        .o_error      (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Capture every RAM write and done pulse shortly after the active edge.
    always @(posedge i_clk) begin
        #1;
        if (o_wr_en) wr_q.push_back({o_wr_addr, o_wr_data});
        if (o_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        logic [ADDR_W+WIDTH-1:0] got;
        got = '1;
        if (wr_q.size() > 0) got = wr_q.pop_front();
        check(tag, 32'(got), 32'({a, d}));
    endtask

    task automatic pulse_start(input logic v, input logic [7:0] b);
        i_start = 1'b1;
        i_byte_valid = v;
        i_byte = b;
        @(negedge i_clk);
        i_start = 1'b0;
        check("start_busy", 32'(o_busy), 32'd1);
        check("start_ready", 32'(o_byte_ready), 32'd1);
    endtask

    // Holds the byte until a handshake edge passes; returns on the following negedge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        i_byte_valid = 1'b1;
        i_byte = b;
        while (!o_byte_ready && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        check("send_accept_timeout", 32'(n < 40), 32'd1);
        @(negedge i_clk);
    endtask

    task automatic end_load(input logic [ADDR_W:0] exp_len, input logic [7:0] csum, input logic exp_err);
`ifdef NOTE_WRITER_CHECKSUM_EN
        send_byte(csum);
`endif
        i_byte_valid = 1'b0;
        check("done_pulse", 32'(o_done), 32'd1);
        @(negedge i_clk);
        check("done_low", 32'(o_done), 32'd0);
        check("busy_idle", 32'(o_busy), 32'd0);
        check("length", 32'(o_length), 32'(exp_len));
        check("error", 32'(o_error), 32'(exp_err));
    endtask

    initial begin
        int d0;
        logic [7:0] x;
        logic [7:0] seq6 [6];
        seq6 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00};

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_byte_valid = 1'b1;
        i_byte = 8'h12;
        repeat (3) @(negedge i_clk);
        check("rst_ready", 32'(o_byte_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_wr_en", 32'(o_wr_en), 32'd0);
        check("rst_addr", 32'(o_wr_addr), 32'd0);
        check("rst_data", 32'(o_wr_data), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_length", 32'(o_length), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        i_rst_n = 1'b1;

        // Idle with valid held high: nothing consumed, nothing written.
        repeat (4) @(negedge i_clk);
        check("idle_ready", 32'(o_byte_ready), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_no_writes", 32'(wr_q.size()), 32'd0);

        // Back-to-back load terminated by END_WORD.
        d0 = done_cnt;
        pulse_start(1'b0, 8'h00);
        for (int i = 0; i < 6; i++) send_byte(seq6[i]);
`ifndef NOTE_WRITER_CHECKSUM_EN
        check("term_wr_en", 32'(o_wr_en), 32'd1);
        check("term_wr_addr", 32'(o_wr_addr), 32'd2);
`endif
        end_load(6'd3, 8'h08, 1'b0);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd1);
        check_write("b2b_w0", 5'd0, 16'h1234);
        check_write("b2b_w1", 5'd1, 16'h5678);
        check_write("b2b_w2", 5'd2, 16'h0000);
        check("b2b_no_extra", 32'(wr_q.size()), 32'd0);
        check("addr_hold", 32'(o_wr_addr), 32'd2);

        // Full-depth load: 17 nonzero words, then the next byte must stall.
        pulse_start(1'b0, 8'h00);
        x = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'h10 + 8'(i));
            send_byte(8'h80 + 8'(i));
            x = x ^ (8'h10 + 8'(i)) ^ (8'h80 + 8'(i));
        end
        end_load(6'd17, x, 1'b0);
        i_byte_valid = 1'b1;
        i_byte = 8'h55;
        repeat (5) @(negedge i_clk);
        check("full_extra_ready", 32'(o_byte_ready), 32'd0);
        check("full_write_count", 32'(wr_q.size()), 32'd17);
        for (int i = 0; i < DEPTH; i++)
            check_write("full_w", 5'(i), {8'h10 + 8'(i), 8'h80 + 8'(i)});
        i_byte_valid = 1'b0;

        // Abort mid-load with a byte offered during the restart strobe.
        d0 = done_cnt;
        pulse_start(1'b0, 8'h00);
        send_byte(8'hAB);
        send_byte(8'h01);
        pulse_start(1'b1, 8'h77);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        end_load(6'd1, 8'h00, 1'b0);
        check("abort_done_count", 32'(done_cnt - d0), 32'd1);
        check_write("abort_w_old", 5'd0, 16'hAB01);
        check_write("abort_w_new", 5'd0, 16'h0000);
        check("abort_no_extra", 32'(wr_q.size()), 32'd0);

        // Valid toggling between bytes.
        d0 = done_cnt;
        pulse_start(1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            send_byte(seq6[i]);
            i_byte_valid = 1'b0;
            i_byte = 8'hEE;
            @(negedge i_clk);
        end
        i_byte_valid = 1'b0;
`ifndef NOTE_WRITER_CHECKSUM_EN
        check("tog_done_count", 32'(done_cnt - d0), 32'd1);
        check("tog_length", 32'(o_length), 32'd3);
`else
        send_byte(8'h08);
        i_byte_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        check("tog_done_count", 32'(done_cnt - d0), 32'd1);
        check("tog_length", 32'(o_length), 32'd3);
        check("tog_error", 32'(o_error), 32'd0);
`endif
        check_write("tog_w0", 5'd0, 16'h1234);
        check_write("tog_w1", 5'd1, 16'h5678);
        check_write("tog_w2", 5'd2, 16'h0000);
        check("tog_no_extra", 32'(wr_q.size()), 32'd0);

`ifdef NOTE_WRITER_CHECKSUM_EN
        pulse_start(1'b0, 8'h00);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h00); send_byte(8'h00);
        end_load(6'd2, 8'h26, 1'b0);
        pulse_start(1'b0, 8'h00);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h00); send_byte(8'h00);
        end_load(6'd2, 8'h27, 1'b1);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("csum_err_cleared", 32'(o_error), 32'd0);
        wr_q.delete();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
